// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART boot loader: receives a framed image, writes words from address 0, then releases the core.
// Frame: SYNC, N[7:0], N[15:8], 4*N little-endian data bytes, XOR checksum over the length and data bytes.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              core_run,
  output logic              load_done,
  output logic              load_err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]    MAX_WORDS = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_LEN0, P_LEN1, P_DATA, P_CSUM, P_DONE, P_ERR} p_state_t;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t       rx_st_q, rx_st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, frame_err;
  logic [7:0]      rx_byte;

  p_state_t        p_st_q, p_st_d;
  logic [7:0]      csum_q, csum_d;
  logic [15:0]     len_q, len_d, n_new;
  logic [ADDR_W:0] widx_q, widx_d;
  logic [1:0]      k_q, k_d;
  logic [23:0]     word_q, word_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            core_run_q, core_run_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;

  assign rx_byte = shift_q;

  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bit_q == 3'd7) rx_st_d = R_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            byte_valid = 1'b1;
            rx_st_d    = R_IDLE;
          end else begin
            frame_err = 1'b1;
            rx_st_d   = R_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_WAIT: begin
        if (rx_s2_q) rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_comb begin
    p_st_d      = p_st_q;
    csum_d      = csum_q;
    len_d       = len_q;
    widx_d      = widx_q;
    k_d         = k_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    core_run_d  = core_run_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    n_new       = {rx_byte, len_q[7:0]};
    if (frame_err && p_st_q != P_DONE && p_st_q != P_ERR) begin
      p_st_d     = P_ERR;
      load_err_d = 1'b1;
    end else if (byte_valid) begin
      case (p_st_q)
        P_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            csum_d = '0;
            widx_d = '0;
            k_d    = '0;
            p_st_d = P_LEN0;
          end
        end
        P_LEN0: begin
          len_d[7:0] = rx_byte;
          csum_d     = csum_q ^ rx_byte;
          p_st_d     = P_LEN1;
        end
        P_LEN1: begin
          len_d  = n_new;
          csum_d = csum_q ^ rx_byte;
          if (32'(n_new) > MAX_WORDS) begin
            p_st_d     = P_ERR;
            load_err_d = 1'b1;
          end else if (n_new == 16'd0) begin
            p_st_d = P_CSUM;
          end else begin
            p_st_d = P_DATA;
          end
        end
        P_DATA: begin
          csum_d = csum_q ^ rx_byte;
          k_d    = k_q + 1'b1;
          case (k_q)
            2'd0: word_d[7:0]   = rx_byte;
            2'd1: word_d[15:8]  = rx_byte;
            2'd2: word_d[23:16] = rx_byte;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = widx_q[ADDR_W-1:0];
              mem_wdata_d = {rx_byte, word_q};
              widx_d      = widx_q + 1'b1;
              if (32'(widx_q) + 32'd1 == 32'(len_q)) p_st_d = P_CSUM;
            end
          endcase
        end
        P_CSUM: begin
          if (rx_byte == csum_q) begin
            p_st_d      = P_DONE;
            core_run_d  = 1'b1;
            load_done_d = 1'b1;
          end else begin
            p_st_d     = P_ERR;
            load_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_st_q     <= R_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      p_st_q      <= P_SYNC;
      csum_q      <= '0;
      len_q       <= '0;
      widx_q      <= '0;
      k_q         <= '0;
      word_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      core_run_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_st_q     <= rx_st_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      p_st_q      <= p_st_d;
      csum_q      <= csum_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      k_q         <= k_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      core_run_q  <= core_run_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign core_run  = core_run_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
